// File: rtl/register_file.sv
// register_file: 16 x 32-bit general register file.
// Two combinational read ports, one write port written on the falling clock edge
// (ALU add/sub result or bus load word), and a tri-state drive of the shared bus
// on register->memory and register->I/O stores.
module register_file #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [DW-1:0] ReadData1,
    output logic [DW-1:0] ReadData2,
    input  logic [AW-1:0] Readreg1,
    input  logic [AW-1:0] Readreg2,
    input  logic [AW-1:0] Writereg,
    input  logic [7:0]    source,
    input  logic [7:0]    destination,
    input  logic          RegWrite,
    input  logic [1:0]    op,
    input  logic [1:0]    type_sel,
    inout  wire  [DW-1:0] data
);

    typedef enum logic [1:0] {
        OP_STORE = 2'b00,
        OP_LOAD  = 2'b01,
        OP_ADD   = 2'b10,
        OP_SUB   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        T_MEM    = 2'b00,
        T_IO_MEM = 2'b01,
        T_MEM2M  = 2'b10,
        T_IO     = 2'b11
    } type_e;

    logic [DW-1:0] r_regs [NREGS];
    logic          w_we;
    logic          w_bus_drive;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b;
    logic          w_unused_addr;

    // Bus address fields are reserved and have no functional effect.
    assign w_unused_addr = ^{source, destination};

    assign w_op_a    = r_regs[Readreg1];
    assign w_op_b    = r_regs[Readreg2];
    assign ReadData1 = w_op_a;
    assign ReadData2 = w_op_b;

    // Write enable: loads between memory/I/O and memory never touch the registers.
    always_comb begin
        w_we = RegWrite;
        if (op_e'(op) == OP_LOAD &&
            (type_e'(type_sel) == T_IO_MEM || type_e'(type_sel) == T_MEM2M)) begin
            w_we = 1'b0;
        end
    end

    // Write data select: ALU result for add/sub, bus word for loads.
    always_comb begin
        w_wdata = data;
        case (op_e'(op))
            OP_ADD:  w_wdata = w_op_a + w_op_b;
            OP_SUB:  w_wdata = w_op_a - w_op_b;
            default: w_wdata = data;
        endcase
    end

    // Register array: async clear, mid-cycle write on the falling edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[Writereg] <= w_wdata;
        end
    end

    // Bus drive: stores to memory or I/O put R[Readreg2] on the bus.
    always_comb begin
        w_bus_drive = 1'b0;
        if (rst_n && op_e'(op) == OP_STORE &&
            (type_e'(type_sel) == T_MEM || type_e'(type_sel) == T_IO)) begin
            w_bus_drive = 1'b1;
        end
    end

    assign data = w_bus_drive ? w_op_b : {DW{1'bz}};

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed steps, expected values from a
// bench-side register model pushed to a scoreboard and popped at each check.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [3:0]  rr1;
    logic [3:0]  rr2;
    logic [3:0]  wr;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic        regwrite;
    logic [1:0]  op;
    logic [1:0]  ttype;
    logic [31:0] tb_bus;
    logic        tb_drive;
    wire  [31:0] data;

    localparam logic [31:0] PROBE = 32'h0F0F_0F0F;

    assign data = tb_drive ? tb_bus : 32'hzzzz_zzzz;

    register_file #(.NREGS(16), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ReadData1  (rd1),
        .ReadData2  (rd2),
        .Readreg1   (rr1),
        .Readreg2   (rr2),
        .Writereg   (wr),
        .source     (src),
        .destination(dst),
        .RegWrite   (regwrite),
        .op         (op),
        .type_sel   (ttype),
        .data       (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] m [16];
    int          checks = 0;
    int          errors = 0;

    task automatic push(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk_rd1(input string tag, input logic [3:0] idx);
        rr1 = idx;
        #1;
        push(tag, m[idx]);
        check(rd1);
    endtask

    task automatic chk_rd2(input string tag, input logic [3:0] idx);
        rr2 = idx;
        #1;
        push(tag, m[idx]);
        check(rd2);
    endtask

    // Bus load into register w (instruction launched just after the rising edge).
    task automatic do_load(input logic [1:0] t, input logic we, input logic [3:0] w,
                           input logic [31:0] v, input logic expect_write);
        @(posedge clk);
        #1;
        op       = 2'b01;
        ttype    = t;
        regwrite = we;
        wr       = w;
        tb_bus   = v;
        tb_drive = 1'b1;
        src      = 8'($urandom);
        dst      = 8'($urandom);
        @(negedge clk);
        #1;
        if (expect_write) m[w] = v;
        regwrite = 1'b0;
        tb_drive = 1'b0;
        op       = 2'b10;
    endtask

    // ALU add/sub; expected value computed from the model before the write edge.
    task automatic do_alu(input logic [1:0] o, input logic [3:0] w,
                          input logic [3:0] a, input logic [3:0] b);
        logic [31:0] res;
        res = (o == 2'b10) ? m[a] + m[b] : m[a] - m[b];
        @(posedge clk);
        #1;
        op       = o;
        ttype    = 2'($urandom);
        regwrite = 1'b1;
        wr       = w;
        rr1      = a;
        rr2      = b;
        src      = 8'($urandom);
        dst      = 8'($urandom);
        @(negedge clk);
        #1;
        m[w]     = res;
        regwrite = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rr1      = '0;
        rr2      = '0;
        wr       = '0;
        src      = '0;
        dst      = '0;
        regwrite = 1'b0;
        op       = 2'b10;
        ttype    = 2'b00;
        tb_bus   = '0;
        tb_drive = 1'b0;
        for (int i = 0; i < 16; i++) m[i] = '0;

        // Reset state: every register reads zero on both ports.
        #2;
        for (int i = 0; i < 16; i++) begin
            chk_rd1("reset_rd1", 4'(i));
            chk_rd2("reset_rd2", 4'(i));
        end
        // Store request during reset must not drive the bus.
        op       = 2'b00;
        ttype    = 2'b00;
        tb_bus   = PROBE;
        tb_drive = 1'b1;
        #1;
        push("reset_bus_release", PROBE);
        check(data);
        tb_drive = 1'b0;
        op       = 2'b10;

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_rd1("post_release_rd1", 4'd9);

        // Load from I/O into R5.
        do_load(2'b11, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b1);
        chk_rd1("load_io_r5", 4'd5);

        // Operands for wrap tests.
        do_load(2'b00, 1'b1, 4'd1, 32'hFFFF_FFFF, 1'b1);
        do_load(2'b00, 1'b1, 4'd2, 32'h0000_0002, 1'b1);
        chk_rd2("load_mem_r1", 4'd1);
        chk_rd2("load_mem_r2", 4'd2);

        do_alu(2'b10, 4'd3, 4'd1, 4'd2);
        push("add_wrap_const", 32'h0000_0001);
        rr1 = 4'd3;
        #1;
        check(rd1);
        do_alu(2'b11, 4'd6, 4'd2, 4'd1);
        push("sub_wrap_const", 32'h0000_0003);
        rr1 = 4'd6;
        #1;
        check(rd1);

        // In-place add: old value visible until the falling edge, then the sum.
        @(posedge clk);
        #1;
        op       = 2'b10;
        regwrite = 1'b1;
        wr       = 4'd1;
        rr1      = 4'd1;
        rr2      = 4'd2;
        #1;
        push("no_bypass_old", 32'hFFFF_FFFF);
        check(rd1);
        @(negedge clk);
        #1;
        regwrite = 1'b0;
        m[1]     = 32'h0000_0001;
        push("inplace_add_new", m[1]);
        check(rd1);

        // Store drive.
        do_load(2'b00, 1'b1, 4'd4, 32'h1234_5678, 1'b1);
        op    = 2'b00;
        ttype = 2'b00;
        rr2   = 4'd4;
        #1;
        push("store_mem_drive", 32'h1234_5678);
        check(data);
        ttype = 2'b11;
        rr2   = 4'd5;
        #1;
        push("store_io_follow_idx", 32'hDEAD_BEEF);
        check(data);
        ttype    = 2'b01;
        rr2      = 4'd4;
        tb_bus   = PROBE;
        tb_drive = 1'b1;
        #1;
        push("store_io_mem_no_drive", PROBE);
        check(data);
        op    = 2'b10;
        ttype = 2'b00;
        #1;
        push("add_no_drive", PROBE);
        check(data);
        op = 2'b11;
        #1;
        push("sub_no_drive", PROBE);
        check(data);
        tb_drive = 1'b0;

        // Write gating: mem->mem and I/O->mem loads, and RegWrite low.
        do_load(2'b10, 1'b1, 4'd7, 32'hAAAA_5555, 1'b0);
        chk_rd1("gate_mem2mem_r7", 4'd7);
        do_load(2'b01, 1'b1, 4'd7, 32'h5555_AAAA, 1'b0);
        chk_rd1("gate_iomem_r7", 4'd7);
        do_load(2'b00, 1'b0, 4'd7, 32'h1111_2222, 1'b0);
        chk_rd1("gate_regwrite_low_r7", 4'd7);
        do_load(2'b00, 1'b1, 4'd0, 32'hCAFE_F00D, 1'b1);
        chk_rd1("reg0_writable", 4'd0);

        // Async reset mid-cycle during an add into R8.
        @(posedge clk);
        #1;
        op       = 2'b10;
        regwrite = 1'b1;
        wr       = 4'd8;
        rr1      = 4'd4;
        rr2      = 4'd5;
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) m[i] = '0;
        push("async_clear_immediate", 32'h0);
        check(rd2);
        @(negedge clk);
        #1;
        chk_rd1("reset_suppresses_write_r8", 4'd8);
        regwrite = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            chk_rd1("after_async_reset", 4'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
